// File: rtl/expr_stream_checker_if.sv
// Character stream and status bundle for the infix expression recogniser.
interface expr_stream_checker_if #(
    parameter int MAX_DEPTH = 7,
    parameter int CNT_W     = 8,
    parameter int POS_W     = 8
);
    localparam int DW = $clog2(MAX_DEPTH + 1);

    logic             in_valid;
    logic [7:0]       in;
    logic             out;
    logic             err;
    logic [DW-1:0]    depth;
    logic [CNT_W-1:0] num_cnt;
    logic [POS_W-1:0] err_pos;

    modport master (
        output in_valid, in,
        input  out, err, depth, num_cnt, err_pos
    );

    modport slave (
        input  in_valid, in,
        output out, err, depth, num_cnt, err_pos
    );
endinterface

// File: rtl/expr_stream_checker.sv
// Byte-serial recogniser for infix expressions: expr := term (op term)*,
// term := number | '(' expr ')'. Tracks nesting, operand count and first error.
//
// state    | meaning
// ---------+------------------------------------------------------
// S_EXPECT | an operand (digit or '(') must come next
// S_NUM    | inside a number, more digits, an operator or ')' allowed
// S_CLOSED | just after ')', operator or another ')' allowed
// S_DEAD   | illegal character seen, absorbing until clr
module expr_stream_checker #(
    parameter int MAX_DIGITS = 4,
    parameter int MAX_DEPTH  = 7,
    parameter int CNT_W      = 8,
    parameter int POS_W      = 8
) (
    input  logic                    clk,
    input  logic                    clr,
    expr_stream_checker_if.slave    bus
);
    localparam int DW   = $clog2(MAX_DEPTH + 1);
    localparam int DIGW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {
        S_EXPECT = 2'd0,
        S_NUM    = 2'd1,
        S_CLOSED = 2'd2,
        S_DEAD   = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [DW-1:0]    r_depth, w_depth_nxt;
    logic [DIGW-1:0]  r_dig, w_dig_nxt;
    logic [CNT_W-1:0] r_num_cnt, w_num_cnt_nxt;
    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] r_err_pos, w_err_pos_nxt;

    logic w_is_digit, w_is_op, w_is_lparen, w_is_rparen;

    assign w_is_digit  = (bus.in >= 8'h30) && (bus.in <= 8'h39);
    assign w_is_op     = (bus.in == 8'h2B) || (bus.in == 8'h2D) ||
                         (bus.in == 8'h2A) || (bus.in == 8'h2F);
    assign w_is_lparen = (bus.in == 8'h28);
    assign w_is_rparen = (bus.in == 8'h29);

    always_comb begin
        w_state_nxt   = r_state;
        w_depth_nxt   = r_depth;
        w_dig_nxt     = r_dig;
        w_num_cnt_nxt = r_num_cnt;
        w_err_pos_nxt = r_err_pos;
        unique case (r_state)
            S_EXPECT: begin
                if (w_is_digit) begin
                    w_state_nxt = S_NUM;
                    w_dig_nxt   = DIGW'(1);
                    if (r_num_cnt != '1)
                        w_num_cnt_nxt = r_num_cnt + CNT_W'(1);
                end else if (w_is_lparen) begin
                    if (r_depth < DW'(MAX_DEPTH))
                        w_depth_nxt = r_depth + DW'(1);
                    else
                        w_state_nxt = S_DEAD;
                end else begin
                    w_state_nxt = S_DEAD;
                end
            end
            S_NUM: begin
                if (w_is_digit) begin
                    if (r_dig < DIGW'(MAX_DIGITS))
                        w_dig_nxt = r_dig + DIGW'(1);
                    else
                        w_state_nxt = S_DEAD;
                end else if (w_is_op) begin
                    w_state_nxt = S_EXPECT;
                end else if (w_is_rparen && (r_depth != '0)) begin
                    w_depth_nxt = r_depth - DW'(1);
                    w_state_nxt = S_CLOSED;
                end else begin
                    w_state_nxt = S_DEAD;
                end
            end
            S_CLOSED: begin
                if (w_is_op)
                    w_state_nxt = S_EXPECT;
                else if (w_is_rparen && (r_depth != '0))
                    w_depth_nxt = r_depth - DW'(1);
                else
                    w_state_nxt = S_DEAD;
            end
            S_DEAD: ;
            default: w_state_nxt = S_DEAD;
        endcase
        // Error position latches only on the transition, so it marks the first offender.
        if ((w_state_nxt == S_DEAD) && (r_state != S_DEAD))
            w_err_pos_nxt = r_pos;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= S_EXPECT;
            r_depth   <= '0;
            r_dig     <= '0;
            r_num_cnt <= '0;
            r_pos     <= '0;
            r_err_pos <= '0;
        end else if (bus.in_valid) begin
            r_state   <= w_state_nxt;
            r_depth   <= w_depth_nxt;
            r_dig     <= w_dig_nxt;
            r_num_cnt <= w_num_cnt_nxt;
            r_err_pos <= w_err_pos_nxt;
            if (r_pos != '1)
                r_pos <= r_pos + POS_W'(1);
        end
    end

    assign bus.out     = ((r_state == S_NUM) || (r_state == S_CLOSED)) && (r_depth == '0);
    assign bus.err     = (r_state == S_DEAD);
    assign bus.depth   = r_depth;
    assign bus.num_cnt = r_num_cnt;
    assign bus.err_pos = r_err_pos;
endmodule

// File: tb/tb_expr_stream_checker.sv
// Directed bench for expr_stream_checker: expected status per character is queued
// when the character is driven and compared after the consuming edge.
module tb_expr_stream_checker;
    logic clk;
    logic clr;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        string      tag;
        logic       out;
        logic       err;
        logic [2:0] depth;
        logic [7:0] num_cnt;
        logic [7:0] err_pos;
    } exp_t;

    exp_t sbq[$];

    expr_stream_checker_if #(.MAX_DEPTH(7), .CNT_W(8), .POS_W(8)) bus ();

    expr_stream_checker #(
        .MAX_DIGITS(4), .MAX_DEPTH(7), .CNT_W(8), .POS_W(8)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all(input string tag, input logic o, input logic e,
                           input int d, input int n, input int p);
        chk({tag, ".out"},     32'(bus.out),     32'(o));
        chk({tag, ".err"},     32'(bus.err),     32'(e));
        chk({tag, ".depth"},   32'(bus.depth),   32'(d));
        chk({tag, ".num_cnt"}, 32'(bus.num_cnt), 32'(n));
        chk({tag, ".err_pos"}, 32'(bus.err_pos), 32'(p));
    endtask

    task automatic pop_check();
        exp_t e;
        total++;
        assert (sbq.size() != 0)
        else begin
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk_all(e.tag, e.out, e.err, int'(e.depth), int'(e.num_cnt), int'(e.err_pos));
        end
    endtask

    // One clock: drive (valid, char), queue the expected status, compare after the edge.
    task automatic send(input logic v, input byte c, input logic eo, input logic ee,
                        input int ed, input int en, input int ep);
        exp_t e;
        @(negedge clk);
        bus.in_valid = v;
        bus.in       = c;
        e.tag     = $sformatf("%s_%c_t%0t", v ? "chr" : "idle", c, $time);
        e.out     = eo;
        e.err     = ee;
        e.depth   = 3'(ed);
        e.num_cnt = 8'(en);
        e.err_pos = 8'(ep);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        pop_check();
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        #2;
        clr = 1'b0;
    endtask

    initial begin
        clr          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in       = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 1'b0, 0, 0, 0);
        @(negedge clk);
        clr = 1'b0;

        // "1+2*3"
        send(1, "1", 1, 0, 0, 1, 0);
        send(1, "+", 0, 0, 0, 1, 0);
        send(1, "2", 1, 0, 0, 2, 0);
        send(1, "*", 0, 0, 0, 2, 0);
        send(1, "3", 1, 0, 0, 3, 0);

        // "(12+3)*4"
        do_clr();
        send(1, "(", 0, 0, 1, 0, 0);
        send(1, "1", 0, 0, 1, 1, 0);
        send(1, "2", 0, 0, 1, 1, 0);
        send(1, "+", 0, 0, 1, 1, 0);
        send(1, "3", 0, 0, 1, 2, 0);
        send(1, ")", 1, 0, 0, 2, 0);
        send(1, "*", 0, 0, 0, 2, 0);
        send(1, "4", 1, 0, 0, 3, 0);

        // five digits overflow MAX_DIGITS=4; DEAD then absorbs further input
        do_clr();
        send(1, "1", 1, 0, 0, 1, 0);
        send(1, "2", 1, 0, 0, 1, 0);
        send(1, "3", 1, 0, 0, 1, 0);
        send(1, "4", 1, 0, 0, 1, 0);
        send(1, "5", 0, 1, 0, 1, 4);
        send(1, "+", 0, 1, 0, 1, 4);
        send(1, "6", 0, 1, 0, 1, 4);

        // eight '(' against MAX_DEPTH=7
        do_clr();
        for (int i = 1; i <= 7; i++)
            send(1, "(", 0, 0, i, 0, 0);
        send(1, "(", 0, 1, 7, 0, 7);

        // "1)" unmatched close
        do_clr();
        send(1, "1", 1, 0, 0, 1, 0);
        send(1, ")", 0, 1, 0, 1, 1);

        // "()" empty group
        do_clr();
        send(1, "(", 0, 0, 1, 0, 0);
        send(1, ")", 0, 1, 1, 0, 1);

        // "1+" dangling operator is incomplete, not an error
        do_clr();
        send(1, "1", 1, 0, 0, 1, 0);
        send(1, "+", 0, 0, 0, 1, 0);

        // digit range edges, '/' operator, then whitespace is illegal
        do_clr();
        send(1, "0", 1, 0, 0, 1, 0);
        send(1, "/", 0, 0, 0, 1, 0);
        send(1, "9", 1, 0, 0, 2, 0);
        send(1, " ", 0, 1, 0, 2, 3);

        // ":" sits just above '9' and must not count as a digit
        do_clr();
        send(1, ":", 0, 1, 0, 0, 0);

        // "(1+" then async clr between edges, then "7" with idle cycles
        do_clr();
        send(1, "(", 0, 0, 1, 0, 0);
        send(1, "1", 0, 0, 1, 1, 0);
        send(1, "-", 0, 0, 1, 1, 0);
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk_all("clr_async", 1'b0, 1'b0, 0, 0, 0);
        #1;
        clr = 1'b0;
        send(1, "7", 1, 0, 0, 1, 0);
        send(0, "(", 1, 0, 0, 1, 0);
        send(0, "x", 1, 0, 0, 1, 0);
        send(1, "*", 0, 0, 0, 1, 0);
        send(0, "5", 0, 0, 0, 1, 0);
        send(1, "5", 1, 0, 0, 2, 0);

        // an edge while clr is held high must be ignored
        @(negedge clk);
        clr          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in       = "5";
        @(posedge clk);
        #1;
        chk_all("clr_held_edge", 1'b0, 1'b0, 0, 0, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        clr          = 1'b0;
        send(1, "8", 1, 0, 0, 1, 0);

        total++;
        assert (sbq.size() == 0)
        else begin
            bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
